// File: rtl/ro_frequency_counter.sv
// Ring-oscillator frequency counter: counts synchronized rising edges of ro_clk
// over a fixed window of GATE_CYCLES reference clocks and strobes the result.
module ro_frequency_counter #(
   parameter int unsigned GATE_CYCLES = 100000,
   parameter int unsigned COUNT_WIDTH = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   continuous,
   input  logic                   ro_clk,
   output logic                   busy,
   output logic                   valid,
   output logic [COUNT_WIDTH-1:0] count,
   output logic                   overflow
);

   localparam int unsigned GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GW-1:0] GATE_LOAD = GW'(GATE_CYCLES - 1);
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic {
      IDLE = 1'b0,
      GATE = 1'b1
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   p_q;
   logic                   rise_s;

   state_t                 state_q, state_d;
   logic [GW-1:0]          gate_q, gate_d;
   logic [COUNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
   logic                   ovf_int_q, ovf_int_d;
   logic                   busy_q, busy_d;
   logic                   valid_q, valid_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   overflow_q, overflow_d;

   logic                   sat_s;
   logic [COUNT_WIDTH-1:0] cnt_next_s;
   logic                   ovf_next_s;

   // Synchronizer chain plus one delay flop for rising-edge detection; runs in every state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         p_q    <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], ro_clk};
         p_q    <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise_s = sync_q[SYNC_STAGES-1] & ~p_q;

   // Saturating increment; an edge arriving at full scale flags overflow.
   always_comb begin
      sat_s      = rise_s & (edge_cnt_q == CNT_MAX);
      cnt_next_s = edge_cnt_q;
      if (rise_s && !sat_s) begin
         cnt_next_s = edge_cnt_q + COUNT_WIDTH'(1);
      end else begin
         cnt_next_s = edge_cnt_q;
      end
      ovf_next_s = ovf_int_q | sat_s;
   end

   // Measurement state and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         gate_q     <= '0;
         edge_cnt_q <= '0;
         ovf_int_q  <= 1'b0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gate_q     <= gate_d;
         edge_cnt_q <= edge_cnt_d;
         ovf_int_q  <= ovf_int_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Next-state logic; valid_q in IDLE marks the cycle right after a result for auto-restart.
   always_comb begin
      state_d    = state_q;
      gate_d     = gate_q;
      edge_cnt_d = edge_cnt_q;
      ovf_int_d  = ovf_int_q;
      busy_d     = busy_q;
      valid_d    = 1'b0;
      count_d    = count_q;
      overflow_d = overflow_q;
      case (state_q)
         IDLE: begin
            if (start || (continuous && valid_q)) begin
               state_d    = GATE;
               gate_d     = GATE_LOAD;
               edge_cnt_d = '0;
               ovf_int_d  = 1'b0;
               busy_d     = 1'b1;
            end else begin
               state_d    = IDLE;
               busy_d     = 1'b0;
            end
         end
         GATE: begin
            edge_cnt_d = cnt_next_s;
            ovf_int_d  = ovf_next_s;
            if (gate_q == '0) begin
               count_d    = cnt_next_s;
               overflow_d = ovf_next_s;
               valid_d    = 1'b1;
               busy_d     = 1'b0;
               state_d    = IDLE;
            end else begin
               gate_d     = gate_q - GW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign busy     = busy_q;
   assign valid    = valid_q;
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_ro_frequency_counter.sv
// Directed bench for ro_frequency_counter: a 32-bit and a 4-bit instance share
// all stimulus; each comparison is an immediate assertion.
module tb_ro_frequency_counter;

   localparam int GATE = 1000;

   logic        clk;
   logic        rst;
   logic        start;
   logic        continuous;
   logic        ro_clk;
   logic        busy, valid, overflow;
   logic [31:0] count;
   logic        busy_s, valid_s, overflow_s;
   logic [3:0]  count_s;

   int          ro_half;
   int          ro_mode;
   int          n_assert;
   int          n_fail;

   ro_frequency_counter #(.GATE_CYCLES(GATE), .COUNT_WIDTH(32), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous), .ro_clk(ro_clk),
      .busy(busy), .valid(valid), .count(count), .overflow(overflow));

   ro_frequency_counter #(.GATE_CYCLES(GATE), .COUNT_WIDTH(4), .SYNC_STAGES(2)) dut_sat (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous), .ro_clk(ro_clk),
      .busy(busy_s), .valid(valid_s), .count(count_s), .overflow(overflow_s));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Oscillator model: toggles off the clk edge grid (2 ns offset), or holds a level.
   initial begin
      ro_clk = 1'b0;
      #2;
      forever begin
         #(ro_half);
         if (ro_mode == 0) ro_clk = ~ro_clk;
         else              ro_clk = (ro_mode == 2);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_rng(input string tag, input longint unsigned obs,
                            input longint unsigned lo, input longint unsigned hi);
      n_assert++;
      assert (obs >= lo && obs <= hi) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   // Runs until dut.valid (bounded); n = ticks from the start cycle, nb = busy cycles seen.
   task automatic run_window(input bit do_start, input int mid_start, input int drop_cont,
                             output int n, output int nb);
      n  = 0;
      nb = 0;
      if (do_start) start = 1'b1;
      while (n < 1500) begin
         tick();
         n++;
         if (n == 1) start = 1'b0;
         if (n == mid_start) start = 1'b1;
         else if (n == mid_start + 1) start = 1'b0;
         if (n == drop_cont) continuous = 1'b0;
         nb += int'(busy);
         if (valid) break;
      end
   endtask

   int n, nb, n1, nv, nbz;
   logic [31:0] held;

   initial begin
      n_assert   = 0;
      n_fail     = 0;
      rst        = 1'b1;
      start      = 1'b0;
      continuous = 1'b0;
      ro_mode    = 0;
      ro_half    = 110;

      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_valid", valid, 0);
      check("rst_count", count, 0);
      check("rst_ovf", overflow, 0);
      rst = 1'b0;
      repeat (20) tick();

      // Basic measurement, 220 ns period.
      run_window(1'b1, -1, -1, n, nb);
      check("basic_latency", n, 1001);
      check("basic_busy_cycles", nb, 1000);
      check_rng("basic_count", count, 45, 46);
      check("basic_ovf", overflow, 0);
      held = count;
      tick();
      check("basic_strobe_len", valid, 0);
      check("basic_count_held", count, held);

      // Static input low, then high.
      ro_mode = 1;
      repeat (30) tick();
      run_window(1'b1, -1, -1, n, nb);
      check("static0_latency", n, 1001);
      check("static0_count", count, 0);
      check("static0_ovf", overflow, 0);
      ro_mode = 2;
      repeat (30) tick();
      run_window(1'b1, -1, -1, n, nb);
      check("static1_count", count, 0);
      check("static1_ovf", overflow, 0);

      // Saturation on the 4-bit instance, 40 ns period (250 edges).
      ro_mode = 0;
      ro_half = 20;
      repeat (50) tick();
      run_window(1'b1, -1, -1, n, nb);
      check("sat_valid_s", valid_s, 1);
      check("sat_count_s", count_s, 15);
      check("sat_ovf_s", overflow_s, 1);
      check_rng("sat_count_wide", count, 249, 251);
      check("sat_ovf_wide", overflow, 0);
      ro_half = 500;
      repeat (200) tick();
      run_window(1'b1, -1, -1, n, nb);
      check("slow_count_s", count_s, 10);
      check("slow_ovf_s", overflow_s, 0);
      check_rng("slow_count_wide", count, 9, 11);

      // Start while busy is ignored; start in the valid cycle is accepted.
      ro_half = 110;
      repeat (50) tick();
      run_window(1'b1, 500, -1, n1, nb);
      check("busy_start_latency", n1, 1001);
      run_window(1'b1, -1, -1, n, nb);
      check("b2b_total", n1 + n, 2002);
      check_rng("b2b_count", count, 45, 46);

      // Asynchronous reset mid-window.
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (399) tick();
      #2 rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_valid", valid, 0);
      check("arst_count", count, 0);
      check("arst_ovf", overflow, 0);
      check("arst_count_s", count_s, 0);
      #1 rst = 1'b0;
      nv  = 0;
      nbz = 0;
      for (int i = 0; i < 1200; i++) begin
         tick();
         nv  += int'(valid);
         nbz += int'(busy);
      end
      check("arst_no_valid", nv, 0);
      check("arst_no_busy", nbz, 0);

      // Continuous mode: three windows, continuous dropped during the third.
      continuous = 1'b1;
      run_window(1'b1, -1, -1, n, nb);
      check("cont1_latency", n, 1001);
      check_rng("cont1_count", count, 45, 46);
      run_window(1'b0, -1, -1, n, nb);
      check("cont2_period", n, 1001);
      check_rng("cont2_count", count, 45, 46);
      run_window(1'b0, -1, 10, n, nb);
      check("cont3_period", n, 1001);
      check_rng("cont3_count", count, 45, 46);
      nv = 0;
      for (int i = 0; i < 1200; i++) begin
         tick();
         nv += int'(valid);
      end
      check("cont_stop_valid", nv, 0);
      check("cont_stop_busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
